// File: rtl/cfg_image_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_image_sequencer
//  Description : Selects and loads FPGA configuration images through a PFL.
//                At power-up it waits for the factory image (CONF_DONE),
//                reads the stored boot index from flash and adopts it. A
//                falling edge on max_csn advances to the next user image
//                (wrapping to 1, never 0). The sequencer pulses nreconfigure
//                and nreset, then waits for CONF_DONE. On success a changed
//                index is written back to flash. On timeout it retries the
//                previous image, then falls back to the factory image.
//  Ports       : clkin_max_100    - sole clock, rising edge
//                sys_resetn       - asynchronous active-low reset
//                max_csn          - async reconfigure request (falling edge)
//                fpga_conf_done   - async FPGA CONF_DONE
//                fl_rd_req/_wr_req- active-low flash controller requests
//                rd_done/wr_done  - one-cycle completion pulses
//                rd_page          - stored boot index, valid with rd_done
//                wr_page          - index to store, stable while writing
//                pfl_flash_access - 1 = PFL owns flash
//                fpga_pgm         - image select to PFL
//                pfl_nreconfigure - active-low reconfigure to PFL
//                pfl_nreset       - active-low reset to PFL
//                busy/cfg_error/retry_cnt - status
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_image_sequencer #(
    parameter int          PAGE_W    = 2,
    parameter int          NUM_PAGES = 3,
    parameter logic [23:0] RCFG_CYC  = 24'hFFFFFF,
    parameter logic [23:0] RST_CYC   = 24'hFFFFFF,
    parameter logic [27:0] WAIT_CYC  = 28'hFFFFFFF,
    parameter int          MAX_RETRY = 2
) (
    input  logic              clkin_max_100,
    input  logic              sys_resetn,
    input  logic              max_csn,
    input  logic              fpga_conf_done,
    output logic              fl_rd_req,
    output logic              fl_wr_req,
    input  logic              rd_done,
    input  logic              wr_done,
    input  logic [PAGE_W-1:0] rd_page,
    output logic [PAGE_W-1:0] wr_page,
    output logic              pfl_flash_access,
    output logic [PAGE_W-1:0] fpga_pgm,
    output logic              pfl_nreconfigure,
    output logic              pfl_nreset,
    output logic              busy,
    output logic              cfg_error,
    output logic [3:0]        retry_cnt
);

    localparam logic [PAGE_W:0]   c_NUM_PAGES = (PAGE_W+1)'(NUM_PAGES);
    localparam logic [PAGE_W-1:0] c_LAST_PAGE = PAGE_W'(NUM_PAGES - 1);
    localparam logic [PAGE_W-1:0] c_PAGE_ONE  = PAGE_W'(1);
    localparam logic [PAGE_W-1:0] c_FACTORY   = '0;
    localparam logic [3:0]        c_MAX_RETRY = 4'(MAX_RETRY);
    localparam logic [27:0]       c_RCFG_END  = {4'd0, RCFG_CYC};
    localparam logic [27:0]       c_RST_END   = {4'd0, RST_CYC};

    typedef enum logic [3:0] {
        S_BOOT_WAIT = 4'd0,
        S_RD_BOOT   = 4'd1,
        S_IDLE      = 4'd2,
        S_SELECT    = 4'd3,
        S_RCFG      = 4'd4,
        S_RST       = 4'd5,
        S_WAIT_DONE = 4'd6,
        S_COMMIT    = 4'd7,
        S_FAIL      = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_csn_meta;
    logic               r_csn_sync;
    logic               r_csn_prev;
    logic               r_cd_meta;
    logic               r_cd_sync;

    logic [27:0]        r_cnt;
    logic [PAGE_W-1:0]  r_fpga_pgm;
    logic [PAGE_W-1:0]  r_committed;
    logic [PAGE_W-1:0]  r_prev;
    logic [PAGE_W-1:0]  r_wr_page;
    logic [3:0]         r_retry_cnt;
    logic               r_cfg_error;

    logic               w_trigger;
    logic               w_commit_write;
    logic [PAGE_W-1:0]  w_next_page;
    logic [PAGE_W-1:0]  w_boot_page;
    logic               w_fl_rd_req;
    logic               w_fl_wr_req;
    logic               w_flash_access;
    logic               w_nreconfigure;
    logic               w_nreset;
    logic               w_busy;

    // Request line idles high, so its synchronizer resets high to avoid a
    // spurious falling edge right after reset.
    always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_csn_meta <= 1'b1;
            r_csn_sync <= 1'b1;
            r_csn_prev <= 1'b1;
            r_cd_meta  <= 1'b0;
            r_cd_sync  <= 1'b0;
        end else begin
            r_csn_meta <= max_csn;
            r_csn_sync <= r_csn_meta;
            r_csn_prev <= r_csn_sync;
            r_cd_meta  <= fpga_conf_done;
            r_cd_sync  <= r_cd_meta;
        end
    end

    assign w_trigger      = r_csn_prev & ~r_csn_sync;
    assign w_commit_write = (r_fpga_pgm != r_committed);
    assign w_next_page    = (r_fpga_pgm >= c_LAST_PAGE) ? c_PAGE_ONE : r_fpga_pgm + c_PAGE_ONE;
    // An out-of-range stored index is treated as the first user image.
    assign w_boot_page    = ({1'b0, rd_page} >= c_NUM_PAGES) ? c_PAGE_ONE : rd_page;

    always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_state <= S_BOOT_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_fl_rd_req    = 1'b1;
        w_fl_wr_req    = 1'b1;
        w_flash_access = 1'b1;
        w_nreconfigure = 1'b1;
        w_nreset       = 1'b1;
        w_busy         = 1'b1;
        case (r_state)
            S_BOOT_WAIT: begin
                if (r_cd_sync) w_state_next = S_RD_BOOT;
            end
            S_RD_BOOT: begin
                w_flash_access = 1'b0;
                w_fl_rd_req    = 1'b0;
                if (rd_done) w_state_next = S_IDLE;
            end
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_trigger) w_state_next = S_SELECT;
            end
            S_SELECT: begin
                w_state_next = S_RCFG;
            end
            S_RCFG: begin
                w_nreconfigure = 1'b0;
                if (r_cnt == c_RCFG_END) w_state_next = S_RST;
            end
            S_RST: begin
                w_nreset = 1'b0;
                if (r_cnt == c_RST_END) w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (r_cd_sync) begin
                    w_state_next = S_COMMIT;
                end else if (r_cnt == WAIT_CYC) begin
                    w_state_next = S_FAIL;
                end
            end
            S_COMMIT: begin
                if (!w_commit_write) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_flash_access = 1'b0;
                    w_fl_wr_req    = 1'b0;
                    if (wr_done) w_state_next = S_IDLE;
                end
            end
            S_FAIL: begin
                // A failed factory image has nowhere left to fall back to.
                if (r_retry_cnt < c_MAX_RETRY) begin
                    w_state_next = S_RCFG;
                end else if (r_fpga_pgm == c_FACTORY) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_RCFG;
                end
            end
            default: begin
                w_state_next = S_BOOT_WAIT;
            end
        endcase
    end

    always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_cnt       <= '0;
            r_fpga_pgm  <= '0;
            r_committed <= '0;
            r_prev      <= '0;
            r_wr_page   <= '0;
            r_retry_cnt <= '0;
            r_cfg_error <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_RCFG || r_state == S_RST || r_state == S_WAIT_DONE) begin
                r_cnt <= r_cnt + 28'd1;
            end

            case (r_state)
                S_RD_BOOT: begin
                    if (rd_done) begin
                        r_committed <= w_boot_page;
                        r_fpga_pgm  <= w_boot_page;
                    end
                end
                S_SELECT: begin
                    r_prev      <= r_fpga_pgm;
                    r_fpga_pgm  <= w_next_page;
                    r_retry_cnt <= '0;
                end
                S_WAIT_DONE: begin
                    // Capture the index once so it is stable for the whole write.
                    if (r_cd_sync) r_wr_page <= r_fpga_pgm;
                end
                S_COMMIT: begin
                    if (!w_commit_write) begin
                        r_cfg_error <= 1'b0;
                    end else if (wr_done) begin
                        r_committed <= r_fpga_pgm;
                        r_cfg_error <= 1'b0;
                    end
                end
                S_FAIL: begin
                    if (r_retry_cnt != 4'd15) r_retry_cnt <= r_retry_cnt + 4'd1;
                    if (r_retry_cnt < c_MAX_RETRY) begin
                        r_fpga_pgm <= r_prev;
                    end else if (r_fpga_pgm == c_FACTORY) begin
                        r_cfg_error <= 1'b1;
                    end else begin
                        r_fpga_pgm  <= c_FACTORY;
                        r_cfg_error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fl_rd_req        = w_fl_rd_req;
    assign fl_wr_req        = w_fl_wr_req;
    assign pfl_flash_access = w_flash_access;
    assign pfl_nreconfigure = w_nreconfigure;
    assign pfl_nreset       = w_nreset;
    assign busy             = w_busy;
    assign wr_page          = r_wr_page;
    assign fpga_pgm         = r_fpga_pgm;
    assign cfg_error        = r_cfg_error;
    assign retry_cnt        = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cfg_image_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfg_image_sequencer
//  Description : Randomized self-checking bench for cfg_image_sequencer with
//                a transaction-level reference model (image sequence per
//                request, write-back expectations, pulse widths).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_image_sequencer;

    localparam int          PW    = 2;
    localparam int          NP    = 3;
    localparam int          MAXR  = 2;
    localparam logic [23:0] RC    = 24'd3;
    localparam logic [23:0] RS    = 24'd3;
    localparam logic [27:0] WC    = 28'd15;
    localparam int          PULSE = 4;

    logic          clk;
    logic          sys_resetn;
    logic          max_csn;
    logic          fpga_conf_done;
    logic          fl_rd_req;
    logic          fl_wr_req;
    logic          rd_done;
    logic          wr_done;
    logic [PW-1:0] rd_page;
    logic [PW-1:0] wr_page;
    logic          pfl_flash_access;
    logic [PW-1:0] fpga_pgm;
    logic          pfl_nreconfigure;
    logic          pfl_nreset;
    logic          busy;
    logic          cfg_error;
    logic [3:0]    retry_cnt;

    cfg_image_sequencer #(
        .PAGE_W(PW), .NUM_PAGES(NP), .RCFG_CYC(RC), .RST_CYC(RS),
        .WAIT_CYC(WC), .MAX_RETRY(MAXR)
    ) dut (
        .clkin_max_100    (clk),
        .sys_resetn       (sys_resetn),
        .max_csn          (max_csn),
        .fpga_conf_done   (fpga_conf_done),
        .fl_rd_req        (fl_rd_req),
        .fl_wr_req        (fl_wr_req),
        .rd_done          (rd_done),
        .wr_done          (wr_done),
        .rd_page          (rd_page),
        .wr_page          (wr_page),
        .pfl_flash_access (pfl_flash_access),
        .fpga_pgm         (fpga_pgm),
        .pfl_nreconfigure (pfl_nreconfigure),
        .pfl_nreset       (pfl_nreset),
        .busy             (busy),
        .cfg_error        (cfg_error),
        .retry_cnt        (retry_cnt)
    );

    typedef struct {
        int page;
        int retry;
        int err;
    } att_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    att_t exp_att[$];
    int   wr_log[$];
    int   nrc_pulses = 0;
    int   nrs_pulses = 0;

    // Reference model state
    int m_flash, m_pgm, m_committed, m_err, m_retry;

    // Stimulus agent state
    int rd_cnt = 0, wr_cnt = 0, cd_cnt = 0, cd_armed = 0;
    int fail_left = 0, cd_dly_max = 8, wr_hold = 0;
    logic prev_nrc = 1'b1, prev_nrs = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int next_page(input int p);
        return (p + 1 >= NP) ? 1 : p + 1;
    endfunction

    function automatic int sanitize(input int p);
        return (p >= NP) ? 1 : p;
    endfunction

    // One clock of stimulus: flash controller, FPGA CONF_DONE behaviour.
    task automatic tick();
        @(negedge clk);
        if (rd_done) rd_done = 1'b0;
        else if (fl_rd_req) rd_cnt = int'($urandom_range(0, 3));
        else if (rd_cnt == 0) begin
            rd_page = PW'(m_flash);
            rd_done = 1'b1;
        end else rd_cnt--;

        if (wr_done) wr_done = 1'b0;
        else if (fl_wr_req) wr_cnt = int'($urandom_range(0, 4));
        else if (wr_hold == 0) begin
            if (wr_cnt == 0) begin
                wr_done = 1'b1;
                wr_log.push_back(int'(wr_page));
                m_flash = int'(wr_page);
            end else wr_cnt--;
        end

        if (sys_resetn && prev_nrc && !pfl_nreconfigure) begin
            fpga_conf_done = 1'b0;
            cd_armed       = 0;
        end
        if (sys_resetn && !prev_nrs && pfl_nreset) begin
            if (fail_left > 0) fail_left--;
            else begin
                cd_armed = 1;
                cd_cnt   = int'($urandom_range(0, cd_dly_max));
            end
        end else if (cd_armed != 0) begin
            if (cd_cnt == 0) begin
                fpga_conf_done = 1'b1;
                cd_armed       = 0;
            end else cd_cnt--;
        end
        prev_nrc = pfl_nreconfigure;
        prev_nrs = pfl_nreset;
    endtask

    task automatic boot(input int flash_val);
        int t;
        tick();
        sys_resetn     = 1'b0;
        fpga_conf_done = 1'b0;
        max_csn        = 1'b1;
        cd_armed       = 0;
        fail_left      = 0;
        exp_att.delete();
        wr_log.delete();
        m_flash = flash_val;
        #1;
        chk("rst_flash_access", int'(pfl_flash_access), 1);
        chk("rst_fl_rd_req", int'(fl_rd_req), 1);
        chk("rst_fl_wr_req", int'(fl_wr_req), 1);
        chk("rst_nreconfigure", int'(pfl_nreconfigure), 1);
        chk("rst_nreset", int'(pfl_nreset), 1);
        chk("rst_busy", int'(busy), 1);
        chk("rst_cfg_error", int'(cfg_error), 0);
        chk("rst_retry_cnt", int'(retry_cnt), 0);
        chk("rst_fpga_pgm", int'(fpga_pgm), 0);
        chk("rst_wr_page", int'(wr_page), 0);
        tick();
        tick();
        sys_resetn = 1'b1;
        repeat (4) tick();
        chk("boot_wait_busy", int'(busy), 1);
        chk("boot_wait_access", int'(pfl_flash_access), 1);
        chk("boot_wait_rd_req", int'(fl_rd_req), 1);
        fpga_conf_done = 1'b1;
        t = 0;
        while (busy && t < 60) begin
            tick();
            t++;
        end
        chk("boot_done_busy", int'(busy), 0);
        m_pgm       = sanitize(flash_val);
        m_committed = m_pgm;
        m_err       = 0;
        m_retry     = 0;
        chk("boot_pgm", int'(fpga_pgm), m_pgm);
        chk("boot_cfg_error", int'(cfg_error), m_err);
        chk("boot_writes", wr_log.size(), 0);
    endtask

    // One reconfigure request whose first k attempts never see CONF_DONE.
    // glitch: 0 none, 1 max_csn pulse in the first WAIT_DONE, 2 during RCFG.
    task automatic run_op(input int k, input int glitch, input int abort);
        int   seq[6];
        int   n_att, nperf, exp_wr, exp_wr_page, base_nrc, base_nrs, t, gl, gl_done;
        int   cur, factory;
        logic last_nrs, last_nrc;
        att_t a;
        cur     = m_pgm;
        n_att   = 0;
        seq[n_att] = next_page(cur);
        n_att++;
        for (int i = 0; i < MAXR; i++) begin
            seq[n_att] = cur;
            n_att++;
        end
        factory = (cur != 0) ? 1 : 0;
        if (factory != 0) begin
            seq[n_att] = 0;
            n_att++;
        end
        nperf = (k >= n_att) ? n_att : k + 1;
        for (int i = 0; i < nperf; i++) begin
            a.page  = seq[i];
            a.retry = i;
            a.err   = (m_err != 0 || (factory != 0 && i == n_att - 1)) ? 1 : 0;
            exp_att.push_back(a);
        end
        exp_wr = 0;
        exp_wr_page = 0;
        if (k >= n_att) begin
            m_pgm   = 0;
            m_err   = 1;
            m_retry = (n_att > 15) ? 15 : n_att;
        end else begin
            m_pgm   = seq[k];
            m_retry = k;
            m_err   = 0;
            if (m_pgm != m_committed) begin
                exp_wr      = 1;
                exp_wr_page = m_pgm;
                m_committed = m_pgm;
            end
        end

        fail_left  = k;
        cd_dly_max = int'($urandom_range(0, 8));
        base_nrc   = nrc_pulses;
        base_nrs   = nrs_pulses;
        wr_log.delete();

        max_csn = 1'b0;
        repeat (3) tick();
        max_csn = 1'b1;
        t = 0;
        while (!busy && t < 10) begin
            tick();
            t++;
        end
        chk("op_started", int'(busy), 1);

        gl = 0;
        gl_done = 0;
        last_nrs = pfl_nreset;
        last_nrc = pfl_nreconfigure;
        t = 0;
        while (busy && t < 800) begin
            tick();
            t++;
            if (gl != 0) begin
                max_csn = 1'b1;
                gl = 0;
            end else if (gl_done == 0 &&
                         ((glitch == 1 && !last_nrs && pfl_nreset) ||
                          (glitch == 2 && last_nrc && !pfl_nreconfigure))) begin
                max_csn = 1'b0;
                gl = 1;
                gl_done = 1;
            end
            if (abort != 0 && !fl_wr_req) begin
                repeat (2) tick();
                chk("wr_req_low_pre_reset", int'(fl_wr_req), 0);
                boot(m_flash);
                wr_hold = 0;
                chk("abort_no_write", wr_log.size(), 0);
                return;
            end
            last_nrs = pfl_nreset;
            last_nrc = pfl_nreconfigure;
        end
        max_csn = 1'b1;
        if (abort != 0) chk("abort_reached_write", 0, abort);
        chk("op_done_busy", int'(busy), 0);
        repeat (8) tick();
        chk("no_queued_trigger", int'(busy), 0);
        fail_left = 0;
        chk("op_fpga_pgm", int'(fpga_pgm), m_pgm);
        chk("op_cfg_error", int'(cfg_error), m_err);
        chk("op_retry_cnt", int'(retry_cnt), m_retry);
        chk("op_nreconfigure_pulses", nrc_pulses - base_nrc, nperf);
        chk("op_nreset_pulses", nrs_pulses - base_nrs, nperf);
        chk("op_missing_attempts", exp_att.size(), 0);
        chk("op_write_count", wr_log.size(), exp_wr);
        if (exp_wr != 0 && wr_log.size() != 0) chk("op_write_page", wr_log[0], exp_wr_page);
        exp_att.delete();
    endtask

    // Per-cycle checks of output relationships and attempt sequencing.
    initial begin : compare_proc
        int   nrc_run, nrs_run, wr_act, wr_ref;
        att_t a;
        nrc_run = 0;
        nrs_run = 0;
        wr_act  = 0;
        wr_ref  = 0;
        forever begin
            @(negedge clk);
            if (!sys_resetn) begin
                nrc_run = 0;
                nrs_run = 0;
                wr_act  = 0;
            end else begin
                chk("flash_owner", int'(pfl_flash_access), int'(fl_rd_req & fl_wr_req));
                if (!pfl_nreconfigure) begin
                    if (nrc_run == 0) begin
                        if (exp_att.size() == 0) begin
                            chk("unexpected_attempt", 1, 0);
                        end else begin
                            a = exp_att.pop_front();
                            chk("attempt_page", int'(fpga_pgm), a.page);
                            chk("attempt_retry_cnt", int'(retry_cnt), a.retry);
                            chk("attempt_cfg_error", int'(cfg_error), a.err);
                        end
                    end
                    nrc_run++;
                end else if (nrc_run != 0) begin
                    chk("nreconfigure_width", nrc_run, PULSE);
                    nrc_pulses++;
                    nrc_run = 0;
                end
                if (!pfl_nreset) nrs_run++;
                else if (nrs_run != 0) begin
                    chk("nreset_width", nrs_run, PULSE);
                    nrs_pulses++;
                    nrs_run = 0;
                end
                if (!fl_wr_req) begin
                    if (wr_act == 0) begin
                        wr_ref = int'(wr_page);
                        chk("wr_page_is_pgm", int'(wr_page), int'(fpga_pgm));
                    end else begin
                        chk("wr_page_stable", int'(wr_page), wr_ref);
                    end
                    wr_act = 1;
                end else begin
                    wr_act = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : main
        int k, g;
        sys_resetn     = 1'b0;
        max_csn        = 1'b1;
        fpga_conf_done = 1'b0;
        rd_done        = 1'b0;
        wr_done        = 1'b0;
        rd_page        = '0;
        m_flash = 0; m_pgm = 0; m_committed = 0; m_err = 0; m_retry = 0;

        // Boot from stored index 2, no write-back
        boot(2);
        chk("boot2_literal_pgm", int'(fpga_pgm), 2);

        // Wrap 2 -> 1 with one write of 1
        run_op(0, 2, 0);
        chk("wrap_literal_pgm", int'(fpga_pgm), 1);
        chk("wrap_literal_wr_count", wr_log.size(), 1);
        if (wr_log.size() != 0) chk("wrap_literal_wr_page", wr_log[0], 1);

        // 1 -> 2 fails, two retries on 1 fail, factory succeeds; request
        // pulse during WAIT_DONE must be ignored
        run_op(3, 1, 0);
        chk("factory_literal_pgm", int'(fpga_pgm), 0);
        chk("factory_literal_retry", int'(retry_cnt), 3);
        chk("factory_literal_err", int'(cfg_error), 0);

        // From factory: every attempt fails, parks on page 0 with error
        run_op(9, 0, 0);
        chk("park_literal_pgm", int'(fpga_pgm), 0);
        chk("park_literal_err", int'(cfg_error), 1);
        chk("park_literal_retry", int'(retry_cnt), 3);

        // Recovery clears the error
        run_op(0, 0, 0);
        chk("recover_literal_pgm", int'(fpga_pgm), 1);
        chk("recover_literal_err", int'(cfg_error), 0);

        // Out-of-range stored index
        boot(3);
        chk("boot3_literal_pgm", int'(fpga_pgm), 1);

        // Reset during the write-back aborts it
        wr_hold = 1;
        run_op(0, 0, 1);
        chk("after_abort_literal_pgm", int'(fpga_pgm), 1);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                boot(int'($urandom_range(0, 3)));
            end else begin
                k = int'($urandom_range(0, 5));
                g = int'($urandom_range(0, 2));
                if (k == 0 && g == 1) g = 2;
                run_op(k, g, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
